// File: rtl/apb_requester_if.sv
// Command, response and APB bus bundle for apb_requester.
// The master modport is the requester side; slave is the sequencer/APB environment side.
interface apb_requester_if #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16
);
  logic                    cmd_valid_i;
  logic                    cmd_ready_o;
  logic                    cmd_write_i;
  logic [ADDRESSWIDTH-1:0] cmd_addr_i;
  logic [DATAWIDTH-1:0]    cmd_wdata_i;
  logic [ADDRESSWIDTH-1:0] PADDR_o;
  logic [DATAWIDTH-1:0]    PWDATA_o;
  logic                    PWRITE_o;
  logic                    PSELx_o;
  logic                    PENABLE_o;
  logic [DATAWIDTH-1:0]    PRDATA_i;
  logic                    PREADY_i;
  logic                    rsp_valid_o;
  logic [DATAWIDTH-1:0]    rsp_rdata_o;
  logic                    rsp_error_o;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, PRDATA_i, PREADY_i,
    output cmd_ready_o, PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o,
           rsp_valid_o, rsp_rdata_o, rsp_error_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, PRDATA_i, PREADY_i,
    input  cmd_ready_o, PADDR_o, PWDATA_o, PWRITE_o, PSELx_o, PENABLE_o,
           rsp_valid_o, rsp_rdata_o, rsp_error_o
  );
endinterface

// File: rtl/apb_requester.sv
// APB initiator: queues register read/write commands and issues them as SETUP/ACCESS
// transfers, returning read data or a timeout error on a one-cycle response strobe.
module apb_requester #(
  parameter int ADDRESSWIDTH = 3,
  parameter int DATAWIDTH    = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_requester_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic                    write;
    logic [ADDRESSWIDTH-1:0] addr;
    logic [DATAWIDTH-1:0]    wdata;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  cmd_t                    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    rst_done;
  logic                    cmd_ready;
  logic                    empty;
  logic                    full;
  logic                    push;
  logic                    pop;
  cmd_t                    head;
  cmd_t                    in_cmd;

  state_t                  state;
  logic [TMO_W-1:0]        tmo_cnt;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDRESSWIDTH-1:0] paddr_q;
  logic [DATAWIDTH-1:0]    pwdata_q;
  logic                    rsp_valid_q;
  logic                    rsp_error_q;
  logic [DATAWIDTH-1:0]    rsp_rdata_q;

  // Ready is held low until the first edge after reset release; a full queue refuses
  // a push even when the head is popped in the same cycle.
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign cmd_ready = rst_done && !full;
  assign push      = bus.cmd_valid_i && cmd_ready;
  assign pop       = !empty && ((state == IDLE) || (state == ACCESS && bus.PREADY_i));
  assign in_cmd    = {bus.cmd_write_i, bus.cmd_addr_i, bus.cmd_wdata_i};
  assign head      = fifo_mem[rd_ptr];

  always_ff @(posedge PCLK) begin
    if (push) fifo_mem[wr_ptr] <= in_cmd;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            paddr_q  <= head.addr;
            pwrite_q <= head.write;
            pwdata_q <= head.write ? head.wdata : '0;
            psel_q   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          tmo_cnt   <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY_i) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA_i;
            penable_q   <= 1'b0;
            // Back-to-back: next command goes straight to SETUP with select held high
            if (!empty) begin
              paddr_q  <= head.addr;
              pwrite_q <= head.write;
              pwdata_q <= head.write ? head.wdata : '0;
              state    <= SETUP;
            end else begin
              psel_q <= 1'b0;
              state  <= IDLE;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = cmd_ready;
  assign bus.PADDR_o     = paddr_q;
  assign bus.PWDATA_o    = pwdata_q;
  assign bus.PWRITE_o    = pwrite_q;
  assign bus.PSELx_o     = psel_q;
  assign bus.PENABLE_o   = penable_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
  assign bus.rsp_error_o = rsp_error_q;
endmodule
